// File: rtl/iob_cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// iob_cache_arb_pkg
// Shared definitions for the cache port arbiter:
//   arb_state_t : FSM encoding (IDLE = no read outstanding, WAIT_R = one read
//                 outstanding)
//   idx_w()     : width of a port index for a given port count (minimum 1)
// -----------------------------------------------------------------------------
package iob_cache_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } arb_state_t;

    // $clog2 returns 0 for n == 1; an index still needs one bit to exist.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_cache_rr_sel.sv
// -----------------------------------------------------------------------------
// iob_cache_rr_sel
// Combinational rotating-priority selector: picks the first set bit of req
// at or after position ptr, wrapping from NPORTS-1 back to 0. With ptr tied
// to zero it degenerates into a lowest-index fixed-priority selector.
//
// Ports:
//   req   [NPORTS-1:0] : request vector
//   ptr   [IW-1:0]     : index with highest priority this cycle
//   gnt   [NPORTS-1:0] : one-hot grant (all zero when no request)
//   idx   [IW-1:0]     : index of the granted port (0 when no request)
//   valid              : at least one request present
// -----------------------------------------------------------------------------
module iob_cache_rr_sel
    import iob_cache_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int IW     = idx_w(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [IW-1:0]     idx,
    output logic              valid
);

    always_comb begin
        int j;
        // NOTE: every variable written here gets a default before any
        // conditional assignment, so no path leaves a value held (no latch).
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            j = (int'(ptr) + k) % NPORTS;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/iob_cache_port_arb.sv
// -----------------------------------------------------------------------------
// iob_cache_port_arb
// Arbitrates NPORTS IOb-native requesters onto one IOb master port toward the
// cache front end. Writes are posted (accept and move on); a read blocks new
// grants until its m_rvalid_i, and the rvalid cycle itself may grant again
// (zero-bubble back-to-back reads). Read data is broadcast; only the owner of
// the outstanding read sees s_rvalid_o.
//
// Build option:
//   IOB_CACHE_ARB_FIXED_PRIO_EN defined   -> fixed priority, port 0 highest,
//                                            no rotating pointer
//   IOB_CACHE_ARB_FIXED_PRIO_EN undefined -> round-robin (default)
//
// Ports:
//   clk_i, arst_n_i, cke_i        : clock, async active-low reset, clock enable
//   s_avalid_i/s_addr_i/s_wdata_i/s_wstrb_i : per-port request, port i at slice i
//   s_ready_o, s_rvalid_o         : per-port accept / read-data valid
//   s_rdata_o                     : read data, shared by all ports
//   m_avalid_o/m_addr_o/m_wdata_o/m_wstrb_o : forwarded request
//   m_ready_i/m_rvalid_i/m_rdata_i          : downstream response
// -----------------------------------------------------------------------------
module iob_cache_port_arb
    import iob_cache_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cke_i,

    input  logic [NPORTS-1:0]          s_avalid_i,
    input  logic [NPORTS*ADDR_W-1:0]   s_addr_i,
    input  logic [NPORTS*DATA_W-1:0]   s_wdata_i,
    input  logic [NPORTS*DATA_W/8-1:0] s_wstrb_i,
    output logic [NPORTS-1:0]          s_ready_o,
    output logic [NPORTS-1:0]          s_rvalid_o,
    output logic [DATA_W-1:0]          s_rdata_o,

    output logic                       m_avalid_o,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    output logic [DATA_W/8-1:0]        m_wstrb_o,
    input  logic                       m_ready_i,
    input  logic                       m_rvalid_i,
    input  logic [DATA_W-1:0]          m_rdata_i
);

    localparam int IW = idx_w(NPORTS);
    localparam int SW = DATA_W / 8;

    arb_state_t  state_q, state_d;
    // owner_q names the port of the outstanding read in WAIT_R, and the
    // stalled port while hold_q is set; the two uses never overlap because a
    // stall never enters WAIT_R.
    logic [IW-1:0] owner_q, owner_d;
    logic          hold_q,  hold_d;
    logic [IW-1:0] ptr;

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`endif

    logic [NPORTS-1:0] rr_gnt;
    logic [IW-1:0]     rr_idx;
    logic              rr_valid;

    iob_cache_rr_sel #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_sel (
        .req   (s_avalid_i),
        .ptr   (ptr),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    logic              held;
    logic              arb_en;
    logic              accept;
    logic              is_read;
    logic [IW-1:0]     sel_idx;
    logic [NPORTS-1:0] sel_gnt;

    // A stalled grant stays with its port while that port keeps requesting,
    // so a newly arriving higher-priority request cannot swap the payload.
    assign held = hold_q && s_avalid_i[owner_q];

    // Arbitrate when nothing is outstanding, or in the cycle the outstanding
    // read completes.
    assign arb_en = (state_q == IDLE) || m_rvalid_i;

    always_comb begin
        sel_gnt = '0;
        sel_idx = rr_idx;
        if (held) begin
            sel_idx          = owner_q;
            sel_gnt[owner_q] = 1'b1;
        end else begin
            sel_gnt = rr_gnt;
        end
    end

    // Output decode
    always_comb begin
        m_avalid_o = arb_en && (held || rr_valid);
        m_addr_o   = s_addr_i [int'(sel_idx)*ADDR_W +: ADDR_W];
        m_wdata_o  = s_wdata_i[int'(sel_idx)*DATA_W +: DATA_W];
        m_wstrb_o  = s_wstrb_i[int'(sel_idx)*SW     +: SW];
        s_ready_o  = m_avalid_o ? (sel_gnt & {NPORTS{m_ready_i}}) : '0;
        s_rvalid_o = '0;
        if (state_q == WAIT_R) s_rvalid_o[owner_q] = m_rvalid_i;
        s_rdata_o  = m_rdata_i;
    end

    assign accept  = m_avalid_o && m_ready_i;
    assign is_read = (m_wstrb_o == '0);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        if (arb_en) begin
            state_d = (accept && is_read) ? WAIT_R : IDLE;
            hold_d  = m_avalid_o && !m_ready_i;
            if (m_avalid_o) owner_d = sel_idx;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
            if (accept) ptr_d = (sel_idx == IW'(NPORTS-1)) ? '0 : sel_idx + 1'b1;
`endif
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            state_q <= IDLE;
            owner_q <= '0;
            hold_q  <= 1'b0;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else if (cke_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_iob_cache_port_arb.sv
// -----------------------------------------------------------------------------
// tb_iob_cache_port_arb
// Self-checking bench for iob_cache_port_arb (NPORTS=4, 32-bit address/data).
// Build-aware: expectations follow IOB_CACHE_ARB_FIXED_PRIO_EN when defined.
// -----------------------------------------------------------------------------
module tb_iob_cache_port_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            cke = 1'b1;
    logic [N-1:0]    s_avalid;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N-1:0]    s_ready;
    logic [N-1:0]    s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            m_avalid;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_ready;
    logic            m_rvalid;
    logic [DW-1:0]   m_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    iob_cache_port_arb #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .cke_i      (cke),
        .s_avalid_i (s_avalid),
        .s_addr_i   (s_addr),
        .s_wdata_i  (s_wdata),
        .s_wstrb_i  (s_wstrb),
        .s_ready_o  (s_ready),
        .s_rvalid_o (s_rvalid),
        .s_rdata_o  (s_rdata),
        .m_avalid_o (m_avalid),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_wstrb_o  (m_wstrb),
        .m_ready_i  (m_ready),
        .m_rvalid_i (m_rvalid),
        .m_rdata_i  (m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        s_avalid = '0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic set_port(input int p, input logic v, input logic [SW-1:0] strb);
        s_avalid[p]           = v;
        s_addr [p*AW +: AW]   = 32'h100 + p;
        s_wdata[p*DW +: DW]   = 32'hD000_0000 + p;
        s_wstrb[p*SW +: SW]   = strb;
    endtask

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        arst_n = 1'b0;
        #1;
        check("reset_m_avalid", m_avalid, 0);
        check("reset_s_ready",  s_ready,  0);
        check("reset_s_rvalid", s_rvalid, 0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // ---------------- table-driven write arbitration ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        int           exp_rr;   // granted port in round-robin build, -1 none
        int           exp_fp;   // granted port in fixed-priority build
    } vec_t;

    task automatic run_table();
        vec_t tbl[11];
        tbl[0]  = '{4'b0000, 1'b1, -1, -1};
        tbl[1]  = '{4'b1111, 1'b1,  0,  0};
        tbl[2]  = '{4'b1111, 1'b1,  1,  0};
        tbl[3]  = '{4'b1001, 1'b1,  3,  0};
        tbl[4]  = '{4'b1001, 1'b1,  0,  0};
        tbl[5]  = '{4'b0001, 1'b1,  0,  0};
        tbl[6]  = '{4'b0100, 1'b1,  2,  2};
        tbl[7]  = '{4'b0011, 1'b0,  0,  0};
        tbl[8]  = '{4'b0011, 1'b0,  0,  0};
        tbl[9]  = '{4'b0010, 1'b1,  1,  1};
        tbl[10] = '{4'b1000, 1'b1,  3,  3};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            int e;
            @(negedge clk);
            clear_inputs();
            for (int p = 0; p < N; p++) set_port(p, tbl[i].req[p], 4'hF);
            m_ready = tbl[i].rdy;
            #1;
            e = FIXED ? tbl[i].exp_fp : tbl[i].exp_rr;
            check("tbl_m_avalid", m_avalid, (e >= 0) ? 1 : 0);
            if (e >= 0) begin
                check("tbl_s_ready", s_ready, tbl[i].rdy ? oh(e) : '0);
                check("tbl_m_addr",  m_addr,  32'h100 + e);
            end
        end
    endtask

    // ---------------- hand-written multi-cycle sequences ----------------
    task automatic seq_all_read();
        int prev;
        prev = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            int g;
            @(negedge clk);
            clear_inputs();
            for (int p = 0; p < N; p++) set_port(p, 1'b1, 4'h0);
            m_ready  = 1'b1;
            m_rvalid = (k > 0);
            m_rdata  = 32'hCAFE_0000 + k;
            #1;
            g = FIXED ? 0 : k % N;
            check("rd4_s_ready",  s_ready,  oh(g));
            check("rd4_s_rvalid", s_rvalid, (k > 0) ? oh(prev) : '0);
            check("rd4_s_rdata",  s_rdata,  32'hCAFE_0000 + k);
            prev = g;
        end
    endtask

    task automatic seq_write_then_next();
        do_reset();
        @(negedge clk);
        clear_inputs();
        set_port(2, 1'b1, 4'hF);
        set_port(3, 1'b1, 4'hF);
        s_addr[2*AW +: AW] = 32'h10;
        m_ready = 1'b1;
        #1;
        check("wr_s_ready", s_ready, 4'b0100);
        check("wr_m_addr",  m_addr,  32'h10);
        check("wr_m_wstrb", m_wstrb, 4'hF);
        @(negedge clk);
        s_avalid[2] = 1'b0;
        #1;
        check("wr_next_m_avalid", m_avalid, 1);
        check("wr_next_s_ready",  s_ready,  4'b1000);
    endtask

    task automatic seq_read_blocks();
        do_reset();
        @(negedge clk);
        clear_inputs();
        set_port(1, 1'b1, 4'h0);
        m_ready = 1'b1;
        #1;
        check("blk_grant1", s_ready, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            clear_inputs();
            set_port(0, 1'b1, 4'hF);
            m_ready = 1'b1;
            #1;
            check("blk_m_avalid", m_avalid, 0);
            check("blk_s_ready",  s_ready,  0);
        end
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        check("blk_rv_s_rvalid", s_rvalid, 4'b0010);
        check("blk_rv_s_ready",  s_ready,  4'b0001);
    endtask

    task automatic seq_stall_hold();
        do_reset();
        @(negedge clk);
        clear_inputs();
        set_port(1, 1'b1, 4'hF);
        #1;
        check("hold_first_addr", m_addr, 32'h101);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_port(0, 1'b1, 4'hF);
            #1;
            check("hold_m_addr",  m_addr,  32'h101);
            check("hold_s_ready", s_ready, 0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        check("hold_release_s_ready", s_ready, 4'b0010);
    endtask

    task automatic seq_reset_mid_read();
        do_reset();
        @(negedge clk);
        clear_inputs();
        set_port(0, 1'b1, 4'h0);
        m_ready = 1'b1;
        #1;
        check("rst_rd_grant", s_ready, 4'b0001);
        @(negedge clk);
        clear_inputs();
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        check("rst_rd_s_rvalid", s_rvalid, 0);
        @(negedge clk);
        clear_inputs();
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 4'hF);
        m_ready = 1'b1;
        #1;
        check("rst_ptr_zero", s_ready, 4'b0001);
    endtask

    task automatic seq_ports_0_3();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] e;
            @(negedge clk);
            clear_inputs();
            set_port(0, 1'b1, 4'h0);
            set_port(3, 1'b1, 4'h0);
            m_ready  = 1'b1;
            m_rvalid = (k > 0);
            #1;
            e = (FIXED || (k % 2 == 0)) ? 4'b0001 : 4'b1000;
            check("p03_s_ready", s_ready, e);
        end
    endtask

    // ---------------- randomized run against a reference model ----------------
    task automatic run_random(input int cycles);
        int outst;    // port owning the outstanding read, -1 when none
        int rr_ptr;   // highest-priority port for the next grant
        int stalled;  // port whose grant was refused last cycle, -1 when none
        outst   = -1;
        rr_ptr  = 0;
        stalled = -1;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            bit           arb;
            int           sel;
            bit           ev;
            logic [SW-1:0] sstrb;
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                s_avalid[p]         = ($urandom_range(0, 99) < 60);
                s_addr [p*AW +: AW] = $urandom;
                s_wdata[p*DW +: DW] = $urandom;
                s_wstrb[p*SW +: SW] = ($urandom_range(0, 1) == 0) ? 4'h0 : SW'($urandom_range(1, 15));
            end
            m_ready  = ($urandom_range(0, 99) < 70);
            m_rvalid = ($urandom_range(0, 99) < 35);
            m_rdata  = $urandom;
            #1;
            arb = (outst < 0) || m_rvalid;
            sel = -1;
            if (stalled >= 0 && s_avalid[stalled]) sel = stalled;
            else
                for (int k = 0; k < N; k++)
                    if (sel < 0 && s_avalid[(rr_ptr + k) % N]) sel = (rr_ptr + k) % N;
            ev = arb && (sel >= 0);
            check("rnd_m_avalid", m_avalid, ev);
            check("rnd_s_ready",  s_ready,  (ev && m_ready) ? oh(sel) : '0);
            check("rnd_s_rvalid", s_rvalid, (outst >= 0 && m_rvalid) ? oh(outst) : '0);
            check("rnd_s_rdata",  s_rdata,  m_rdata);
            if (ev) begin
                sstrb = s_wstrb[sel*SW +: SW];
                check("rnd_m_addr",  m_addr,  s_addr [sel*AW +: AW]);
                check("rnd_m_wdata", m_wdata, s_wdata[sel*DW +: DW]);
                check("rnd_m_wstrb", m_wstrb, sstrb);
            end else begin
                sstrb = '0;
            end
            if (arb) begin
                outst   = (ev && m_ready && sstrb == 0) ? sel : -1;
                stalled = (ev && !m_ready) ? sel : -1;
                if (ev && m_ready && !FIXED) rr_ptr = (sel + 1) % N;
            end
        end
    endtask

    initial begin
        clear_inputs();
        run_table();
        seq_all_read();
        seq_write_then_next();
        seq_read_blocks();
        seq_stall_hold();
        seq_reset_mid_read();
        seq_ports_0_3();
        run_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iob_cache_port_arb.md
IOB_CACHE_PORT_ARB -- requirements
Module: iob_cache_port_arb

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of IOb-native requester ports, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32, word address width per port.
REQ-003 SHALL have parameter DATA_W, default 32, data width, multiple of 8.
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port arst_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cke_i, input, 1, clock enable; state holds when low.
REQ-007 SHALL have port s_avalid_i, input, NPORTS, per-port request valid.
REQ-008 SHALL have port s_addr_i, input, NPORTS*ADDR_W, per-port address, port i at slice i.
REQ-009 SHALL have port s_wdata_i, input, NPORTS*DATA_W, per-port write data.
REQ-010 SHALL have port s_wstrb_i, input, NPORTS*DATA_W/8, per-port write strobe; all-zero means read.
REQ-011 SHALL have port s_ready_o, output, NPORTS, per-port accept.
REQ-012 SHALL have port s_rvalid_o, output, NPORTS, per-port read-data valid.
REQ-013 SHALL have port s_rdata_o, output, DATA_W, read data broadcast to all ports.
REQ-014 SHALL have ports m_avalid_o/m_addr_o/m_wdata_o/m_wstrb_o (outputs) and m_ready_i/m_rvalid_i/m_rdata_i (inputs), IOb master toward the cache front end, widths as per-port.

Function
REQ-015 SHALL accept a request on port i when s_avalid_i[i] and s_ready_o[i] are both high in the same cycle.
REQ-016 SHALL use a two-state FSM: IDLE (no read outstanding) and WAIT_R (one read outstanding, owner index stored).
REQ-017 SHALL, in IDLE, select one requesting port combinationally, drive m_avalid_o=1 with that port's addr/wdata/wstrb, and set s_ready_o[sel]=m_ready_i, all other s_ready_o=0.
REQ-018 SHALL, by default, select round-robin: the first requesting port at or after pointer ptr, wrapping NPORTS-1 -> 0.
REQ-019 SHALL, on accept, set ptr to sel+1 modulo NPORTS.
REQ-020 SHALL, on accept of a write (wstrb nonzero), remain in IDLE; a new grant is possible the next cycle.
REQ-021 SHALL, on accept of a read, store owner=sel and go to WAIT_R; m_avalid_o=0 and all s_ready_o=0 in WAIT_R except as in REQ-023.
REQ-022 SHALL, in WAIT_R, drive s_rvalid_o[owner]=m_rvalid_i and s_rvalid_o of all other ports 0; s_rdata_o=m_rdata_i always.
REQ-023 SHALL, in the WAIT_R cycle with m_rvalid_i=1, behave as IDLE for arbitration (back-to-back accept allowed, zero bubble); the next state is then WAIT_R for an accepted read, else IDLE.
REQ-024 SHALL ignore m_rvalid_i in IDLE: no s_rvalid_o asserted.
REQ-025 SHALL hold a granted-but-not-ready request (m_ready_i=0) stable; selection and ptr SHALL NOT change while the selected s_avalid_i stays high.
REQ-026 SHALL, when no port requests, drive m_avalid_o=0 and leave ptr unchanged.

Reset
REQ-027 SHALL, while arst_n_i=0, force state=IDLE, ptr=0, owner=0, hold=0 asynchronously; outputs derive from that state with m_avalid_o=0, s_ready_o=0 and s_rvalid_o=0 when no inputs are active.
REQ-028 SHALL, on reset mid-read, discard the outstanding read; a later m_rvalid_i is ignored per REQ-024.

Configuration
REQ-029 SHALL, with IOB_CACHE_ARB_FIXED_PRIO_EN defined, select the lowest-index requesting port (port 0 highest priority) and not implement ptr.
REQ-030 SHALL, without IOB_CACHE_ARB_FIXED_PRIO_EN, use round-robin per REQ-018/019.

Structure
REQ-031 SHALL place FSM state encoding (IDLE=0, WAIT_R=1) and the $clog2(NPORTS) index-width function in package iob_cache_arb_pkg.
REQ-032 SHALL implement selection in one sub-module iob_cache_rr_sel (inputs: request vector and ptr; outputs: one-hot grant and index).

Verification
REQ-033 SHALL cover: ports 0,1,2,3 all read continuously, m_ready_i=1, 1-cycle rvalid -> grants 0,1,2,3,0, each rvalid only on the owner.
REQ-034 SHALL cover: port 2 write wstrb=4'hF addr=0x10 with m_ready_i=1 -> accepted in 1 cycle, FSM stays IDLE, port 3 granted the next cycle.
REQ-035 SHALL cover: port 1 read, m_rvalid_i after 5 cycles, port 0 requesting throughout -> port 0 blocked for 5 cycles, then accepted in the rvalid cycle.
REQ-036 SHALL cover: m_ready_i=0 for 3 cycles with port 1 selected and port 0 newly requesting -> m_addr_o stays at port 1 address, no switch.
REQ-037 SHALL cover: arst_n_i pulsed low in WAIT_R, then m_rvalid_i=1 -> all s_rvalid_o=0 and ptr=0.
REQ-038 SHALL cover: IOB_CACHE_ARB_FIXED_PRIO_EN defined, ports 0 and 3 reading continuously -> port 3 never granted.
